// File: rtl/lsu_pkg.sv
// Shared widths, func3 encodings, response codes and FSM states for the LSU.
// Misalignment is decided here so the FSM and any future users agree on it.
package lsu_pkg;

  localparam int CPU_BUS = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_DONE
  } state_e;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// AXI4-Lite-style memory port of the LSU; the LSU drives the master side.
interface lsu_if import lsu_pkg::*; #(parameter int XLEN = CPU_BUS);
  logic            arvalid, arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid, rready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            awvalid, awready;
  logic [XLEN-1:0] awaddr;
  logic            wvalid, wready;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            bvalid, bready;
  logic [1:0]      bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend from the read word, store shift and
// strobe generation for the write channel. Purely combinational.
module lsu_align import lsu_pkg::*; #(
  parameter int XLEN = CPU_BUS
) (
  input  logic [2:0]      func3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] st_src,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_data,
  output logic [3:0]      st_strb
);

  logic [XLEN-1:0] byte_sh, half_sh;

  always_comb begin
    byte_sh = rdata >> {off, 3'b000};
    half_sh = rdata >> {off[1], 4'b0000};
    case (func3)
      F3_B:    ld_data = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      F3_H:    ld_data = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: ld_data = rdata;
    endcase

    st_data = st_src << {off, 3'b000};
    case (func3[1:0])
      2'b00:   st_strb = 4'b0001 << off;
      2'b01:   st_strb = 4'b0011 << off;
      default: st_strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes one instruction from EXU, runs loads/stores on the
// memory port, and presents rd/err to WBU until it is taken.
module lsu import lsu_pkg::*; #(
  parameter int XLEN = CPU_BUS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pre_valid,
  output logic            o_pre_ready,
  input  logic            i_lsu_ren,
  input  logic            i_lsu_wen,
  input  logic [2:0]      i_lsu_func3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  input  logic [XLEN-1:0] i_lsu_alu_res,
  lsu_if.master           mem,
  output logic            o_post_valid,
  input  logic            i_post_ready,
  output logic [XLEN-1:0] o_lsu_rd,
  output logic            o_lsu_err
);

  typedef struct packed {
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            err_q, err_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic [XLEN-1:0] ld_data, st_data, word_addr;
  logic [3:0]      st_strb;
  logic            in_wr;

  lsu_align #(.XLEN(XLEN)) u_align (
    .func3   (req_q.func3),
    .off     (req_q.addr[1:0]),
    .rdata   (mem.rdata),
    .st_src  (req_q.wdata),
    .ld_data (ld_data),
    .st_data (st_data),
    .st_strb (st_strb)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rd_d      = rd_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: if (i_pre_valid) begin
        req_d     = '{func3: i_lsu_func3, addr: i_lsu_addr, wdata: i_lsu_wdata};
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rd_d      = '0;
        err_d     = 1'b0;
        if (!(i_lsu_ren || i_lsu_wen)) begin
          state_d = S_DONE;
          rd_d    = i_lsu_alu_res;
        end else if (misaligned(i_lsu_func3, i_lsu_addr[1:0])) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          // ren wins when both are set
          state_d = i_lsu_ren ? S_AR : S_WR;
        end
      end
      S_AR: if (mem.arready) state_d = S_R;
      S_R: if (mem.rvalid) begin
        rd_d    = ld_data;
        err_d   = mem.rresp != RESP_OKAY;
        state_d = S_DONE;
      end
      S_WR: begin
        // AW and W retire independently; move on once both have been seen
        aw_done_d = aw_done_q | mem.awready;
        w_done_d  = w_done_q | mem.wready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: if (mem.bvalid) begin
        rd_d    = '0;
        err_d   = mem.bresp != RESP_OKAY;
        state_d = S_DONE;
      end
      S_DONE: if (i_post_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign word_addr   = {req_q.addr[XLEN-1:2], 2'b00};
  assign in_wr       = state_q == S_WR;

  assign o_pre_ready = state_q == S_IDLE;
  assign mem.arvalid = state_q == S_AR;
  assign mem.araddr  = (state_q == S_AR) ? word_addr : '0;
  assign mem.rready  = state_q == S_R;
  assign mem.awvalid = in_wr && !aw_done_q;
  assign mem.awaddr  = in_wr ? word_addr : '0;
  assign mem.wvalid  = in_wr && !w_done_q;
  assign mem.wdata   = in_wr ? st_data : '0;
  assign mem.wstrb   = in_wr ? st_strb : 4'b0000;
  assign mem.bready  = state_q == S_B;

  assign o_post_valid = state_q == S_DONE;
  assign o_lsu_rd     = rd_q;
  assign o_lsu_err    = err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized traffic against a
// behavioural model, with a delay-programmable memory slave and bus monitor.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pre_valid, i_lsu_ren, i_lsu_wen, i_post_ready;
  logic [2:0]  i_lsu_func3;
  logic [31:0] i_lsu_addr, i_lsu_wdata, i_lsu_alu_res;
  logic        o_pre_ready, o_post_valid, o_lsu_err;
  logic [31:0] o_lsu_rd;

  lsu_if #(.XLEN(32)) mif();

  lsu #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pre_valid   (i_pre_valid),
    .o_pre_ready   (o_pre_ready),
    .i_lsu_ren     (i_lsu_ren),
    .i_lsu_wen     (i_lsu_wen),
    .i_lsu_func3   (i_lsu_func3),
    .i_lsu_addr    (i_lsu_addr),
    .i_lsu_wdata   (i_lsu_wdata),
    .i_lsu_alu_res (i_lsu_alu_res),
    .mem           (mif.master),
    .o_post_valid  (o_post_valid),
    .i_post_ready  (i_post_ready),
    .o_lsu_rd      (o_lsu_rd),
    .o_lsu_err     (o_lsu_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // slave knobs set by tests
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] rd_val = '0;
  logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;

  // monitor results
  int          ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, bus_vld = 0;
  logic [31:0] ar_addr = '0, aw_addr = '0, w_data = '0;
  logic [3:0]  w_strb = '0;

  // Memory slave: each ready/valid pulses for one cycle after its delay.
  initial begin
    int ar_w, r_w, aw_w, w_w, b_w;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    mif.arready = 0; mif.rvalid = 0; mif.rdata = '0; mif.rresp = '0;
    mif.awready = 0; mif.wready = 0; mif.bvalid = 0; mif.bresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mif.arready = 0; mif.rvalid = 0; mif.awready = 0; mif.wready = 0; mif.bvalid = 0;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
      end else begin
        if (mif.arready) mif.arready = 0;
        else if (mif.arvalid) begin
          if (ar_w >= ar_dly) begin mif.arready = 1; ar_w = 0; end else ar_w++;
        end
        if (mif.rvalid) mif.rvalid = 0;
        else if (mif.rready) begin
          if (r_w >= r_dly) begin
            mif.rvalid = 1; mif.rdata = rd_val; mif.rresp = rresp_val; r_w = 0;
          end else r_w++;
        end
        if (mif.awready) mif.awready = 0;
        else if (mif.awvalid) begin
          if (aw_w >= aw_dly) begin mif.awready = 1; aw_w = 0; end else aw_w++;
        end
        if (mif.wready) mif.wready = 0;
        else if (mif.wvalid) begin
          if (w_w >= w_dly) begin mif.wready = 1; w_w = 0; end else w_w++;
        end
        if (mif.bvalid) mif.bvalid = 0;
        else if (mif.bready) begin
          if (b_w >= b_dly) begin mif.bvalid = 1; mif.bresp = bresp_val; b_w = 0; end else b_w++;
        end
      end
    end
  end

  // Monitor samples 1 time unit before each rising edge.
  initial forever begin
    @(negedge clk); #4;
    if (!rst) begin
      if (mif.arvalid && mif.arready) begin ar_hs++; ar_addr = mif.araddr; end
      if (mif.rvalid && mif.rready) r_hs++;
      if (mif.awvalid && mif.awready) begin aw_hs++; aw_addr = mif.awaddr; end
      if (mif.wvalid && mif.wready) begin w_hs++; w_data = mif.wdata; w_strb = mif.wstrb; end
      if (mif.bvalid && mif.bready) b_hs++;
      if (mif.arvalid || mif.awvalid || mif.wvalid) bus_vld++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] a, input logic [31:0] w);
    int off = int'(a % 4);
    logic [31:0] v;
    case (f3)
      0, 4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v | 32'hFFFF_FF00;
      end
      1, 5: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] a, input logic [31:0] rs2);
    return rs2 * (32'd1 << (8 * (a % 4)));
  endfunction

  function automatic logic [3:0] ref_strb(input int f3, input logic [31:0] a);
    int off = int'(a % 4);
    case (f3)
      0:       return 4'(1 << off);
      1:       return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic bit ref_misaligned(input int f3, input logic [31:0] a);
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1;
    if (f3 == 2 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu);
    i_lsu_ren = ren; i_lsu_wen = wen; i_lsu_func3 = f3;
    i_lsu_addr = addr; i_lsu_wdata = wd; i_lsu_alu_res = alu;
    i_pre_valid = 1;
    @(posedge clk); #1;
    i_pre_valid = 0;
    i_lsu_ren = 1'($urandom); i_lsu_wen = 1'($urandom); i_lsu_func3 = 3'($urandom);
    i_lsu_addr = $urandom; i_lsu_wdata = $urandom; i_lsu_alu_res = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!o_post_valid && cyc < 200);
  endtask

  task automatic retire();
    i_post_ready = 1;
    @(posedge clk); #1;
    i_post_ready = 0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({o_pre_ready, o_post_valid, o_lsu_err, mif.arvalid, mif.rready, mif.awvalid, mif.wvalid, mif.bready} !== 8'b1000_0000) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=10000000",
        {o_pre_ready, o_post_valid, o_lsu_err, mif.arvalid, mif.rready, mif.awvalid, mif.wvalid, mif.bready});
    end
    checks++;
    if ({o_lsu_rd, mif.araddr, mif.wdata, mif.wstrb} !== '0) begin
      fails++; $display("FAIL reset_data rd=%h araddr=%h wdata=%h wstrb=%b", o_lsu_rd, mif.araddr, mif.wdata, mif.wstrb);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_nonmem();
    int cyc, b0;
    b0 = bus_vld;
    issue(0, 0, 3'b010, 32'h8000_0001, 32'hDEAD_BEEF, 32'h1234);
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin fails++; $display("FAIL nonmem_latency got=%0d exp=1", cyc); end
    checks++;
    if (o_lsu_rd !== 32'h1234 || o_lsu_err !== 1'b0) begin
      fails++; $display("FAIL nonmem_rd got=%h/%b exp=00001234/0", o_lsu_rd, o_lsu_err);
    end
    retire();
    checks++;
    if (bus_vld !== b0) begin fails++; $display("FAIL nonmem_bus got=%0d exp=%0d", bus_vld, b0); end
    checks++;
    if (o_post_valid !== 1'b0 || o_pre_ready !== 1'b1) begin
      fails++; $display("FAIL nonmem_drop got=%b%b exp=01", o_post_valid, o_pre_ready);
    end
  endtask

  task automatic test_load_byte();
    int cyc, a0, aw0;
    rd_val = 32'h80FF_FFFF; rresp_val = 2'b00;
    a0 = ar_hs;
    issue(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h0);
    wait_done(cyc);
    checks++;
    if (cyc !== 3) begin fails++; $display("FAIL lb_latency got=%0d exp=3", cyc); end
    checks++;
    if (ar_hs - a0 !== 1 || ar_addr !== 32'h8000_0000) begin
      fails++; $display("FAIL lb_araddr got=%h n=%0d exp=80000000 n=1", ar_addr, ar_hs - a0);
    end
    checks++;
    if (o_lsu_rd !== 32'hFFFF_FF80 || o_lsu_err !== 1'b0) begin
      fails++; $display("FAIL lb_rd got=%h/%b exp=ffffff80/0", o_lsu_rd, o_lsu_err);
    end
    retire();
    // ren+wen together must behave as a load
    aw0 = aw_hs;
    issue(1, 1, 3'b100, 32'h8000_0003, 32'h5555_5555, 32'h0);
    wait_done(cyc);
    checks++;
    if (o_lsu_rd !== 32'h0000_0080 || aw_hs !== aw0) begin
      fails++; $display("FAIL lbu_rd got=%h aw=%0d exp=00000080 aw=%0d", o_lsu_rd, aw_hs, aw0);
    end
    retire();
  endtask

  task automatic test_store();
    int cyc, aw0, w0;
    aw_dly = 3; w_dly = 0; bresp_val = 2'b00;
    aw0 = aw_hs; w0 = w_hs;
    issue(0, 1, 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 32'h0);
    wait_done(cyc);
    checks++;
    if (cyc !== 6) begin fails++; $display("FAIL sh_latency got=%0d exp=6", cyc); end
    checks++;
    if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
      fails++; $display("FAIL sh_handshakes got aw=%0d w=%0d exp=1/1", aw_hs - aw0, w_hs - w0);
    end
    checks++;
    if (aw_addr !== 32'h8000_0000 || w_data !== 32'hBEEF_0000 || w_strb !== 4'b1100) begin
      fails++; $display("FAIL sh_bus got=%h/%h/%b exp=80000000/beef0000/1100", aw_addr, w_data, w_strb);
    end
    checks++;
    if (o_lsu_rd !== 32'h0 || o_lsu_err !== 1'b0) begin
      fails++; $display("FAIL sh_rd got=%h/%b exp=0/0", o_lsu_rd, o_lsu_err);
    end
    retire();
    aw_dly = 0;
    issue(0, 1, 3'b000, 32'h8000_0101, 32'h1234_56A5, 32'h0);
    wait_done(cyc);
    checks++;
    if (cyc !== 3 || w_data !== 32'h3456_A500 || w_strb !== 4'b0010 || aw_addr !== 32'h8000_0100) begin
      fails++; $display("FAIL sb_bus got cyc=%0d %h/%b/%h exp cyc=3 3456a500/0010/80000100", cyc, w_data, w_strb, aw_addr);
    end
    retire();
  endtask

  task automatic test_misalign();
    int cyc, b0;
    b0 = bus_vld;
    issue(1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h7777);
    wait_done(cyc);
    checks++;
    if (cyc !== 1 || o_lsu_err !== 1'b1 || o_lsu_rd !== 32'h0) begin
      fails++; $display("FAIL misalign got cyc=%0d err=%b rd=%h exp cyc=1 err=1 rd=0", cyc, o_lsu_err, o_lsu_rd);
    end
    retire();
    checks++;
    if (bus_vld !== b0) begin fails++; $display("FAIL misalign_bus got=%0d exp=%0d", bus_vld, b0); end
  endtask

  task automatic test_err_stall();
    int cyc;
    logic [31:0] rd0;
    rd_val = 32'hCAFE_F00D; rresp_val = 2'b10;
    issue(1, 0, 3'b010, 32'h8000_0040, 32'h0, 32'h0);
    wait_done(cyc);
    rresp_val = 2'b00;
    checks++;
    if (cyc !== 3 || o_lsu_err !== 1'b1) begin
      fails++; $display("FAIL rresp_err got cyc=%0d err=%b exp cyc=3 err=1", cyc, o_lsu_err);
    end
    rd0 = o_lsu_rd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_post_valid !== 1'b1 || o_pre_ready !== 1'b0 || o_lsu_rd !== rd0 || o_lsu_err !== 1'b1) begin
        fails++; $display("FAIL stall_hold cyc%0d got v=%b r=%b rd=%h exp v=1 r=0 rd=%h", i, o_post_valid, o_pre_ready, o_lsu_rd, rd0);
      end
    end
    retire();
    checks++;
    if (o_post_valid !== 1'b0 || o_pre_ready !== 1'b1) begin
      fails++; $display("FAIL stall_drop got=%b%b exp=01", o_post_valid, o_pre_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    r_dly = 6;
    issue(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'h0);
    n = 0;
    while (!mif.rready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1; #1;
    checks++;
    if ({o_pre_ready, o_post_valid, o_lsu_err, mif.arvalid, mif.rready, mif.awvalid, mif.wvalid, mif.bready} !== 8'b1000_0000
        || o_lsu_rd !== 32'h0 || n >= 20) begin
      fails++; $display("FAIL reset_mid got ctrl=%b rd=%h n=%0d exp ctrl=10000000 rd=0",
        {o_pre_ready, o_post_valid, o_lsu_err, mif.arvalid, mif.rready, mif.awvalid, mif.wvalid, mif.bready}, o_lsu_rd, n);
    end
    repeat (2) @(negedge clk);
    rst = 0; r_dly = 0;
    @(negedge clk);
    rd_val = 32'h8001_1234;
    issue(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h0);
    wait_done(cyc);
    checks++;
    if (cyc !== 3 || o_lsu_rd !== 32'hFFFF_8001 || o_lsu_err !== 1'b0) begin
      fails++; $display("FAIL after_reset got cyc=%0d rd=%h err=%b exp cyc=3 rd=ffff8001 err=0", cyc, o_lsu_rd, o_lsu_err);
    end
    retire();
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int t = 0; t < 60; t++) begin
      int kind, f3, cyc, a0, aw0, w0, ea, eaw, ew;
      logic ren, wen, mis, eerr;
      logic [31:0] addr, rs2, alu, erd;
      kind = $urandom_range(0, 3);
      ren = (kind == 1 || kind == 3); wen = (kind == 2 || kind == 3);
      f3 = wen && !ren ? $urandom_range(0, 2) : int'(ld_f3[$urandom_range(0, 4)]);
      addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | $urandom_range(0, 3);
      rs2 = $urandom; alu = $urandom; rd_val = $urandom;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      rresp_val = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bresp_val = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mis = (ren || wen) && ref_misaligned(f3, addr);
      ea = 0; eaw = 0; ew = 0;
      if (!ren && !wen)  begin erd = alu; eerr = 0; end
      else if (mis)      begin erd = 0; eerr = 1; end
      else if (ren)      begin erd = ref_load(f3, addr, rd_val); eerr = rresp_val != 0; ea = 1; end
      else               begin erd = 0; eerr = bresp_val != 0; eaw = 1; ew = 1; end
      a0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
      issue(ren, wen, 3'(f3), addr, rs2, alu);
      wait_done(cyc);
      checks++;
      if (o_post_valid !== 1'b1) begin fails++; $display("FAIL rnd%0d_timeout got=%b exp=1", t, o_post_valid); end
      checks++;
      if (o_lsu_rd !== erd || o_lsu_err !== eerr) begin
        fails++; $display("FAIL rnd%0d_result k=%0d f3=%0d a=%h got=%h/%b exp=%h/%b", t, kind, f3, addr, o_lsu_rd, o_lsu_err, erd, eerr);
      end
      retire();
      checks++;
      if (ar_hs - a0 !== ea || aw_hs - aw0 !== eaw || w_hs - w0 !== ew) begin
        fails++; $display("FAIL rnd%0d_hs got=%0d/%0d/%0d exp=%0d/%0d/%0d", t, ar_hs - a0, aw_hs - aw0, w_hs - w0, ea, eaw, ew);
      end
      if (ea == 1) begin
        checks++;
        if (ar_addr !== (addr & 32'hFFFF_FFFC)) begin
          fails++; $display("FAIL rnd%0d_araddr got=%h exp=%h", t, ar_addr, addr & 32'hFFFF_FFFC);
        end
      end
      if (eaw == 1) begin
        checks++;
        if (aw_addr !== (addr & 32'hFFFF_FFFC) || w_data !== ref_wdata(addr, rs2) || w_strb !== ref_strb(f3, addr)) begin
          fails++; $display("FAIL rnd%0d_store got=%h/%h/%b exp=%h/%h/%b", t, aw_addr, w_data, w_strb,
            addr & 32'hFFFF_FFFC, ref_wdata(addr, rs2), ref_strb(f3, addr));
        end
      end
    end
  endtask

  initial begin
    rst = 1; i_pre_valid = 0; i_post_ready = 0;
    i_lsu_ren = 0; i_lsu_wen = 0; i_lsu_func3 = '0;
    i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_alu_res = '0;
    test_reset();
    test_nonmem();
    test_load_byte();
    test_store();
    test_misalign();
    test_err_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit of the multi-cycle NPC. Sits between the EXU (upstream) and the WBU (downstream).
- Accepts one instruction per handshake from EXU.
- Loads and stores run over an AXI4-Lite-style master port; all other instructions pass the ALU result straight through.
- Presents the result to WBU as the transmitting end of the valid/ready link that WBU receives.

Parameters:
- XLEN, 32, data/address width (matches `CPU_Bus).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_pre_valid  in  1  EXU data valid
- o_pre_ready  out  1  LSU idle, can accept
- i_lsu_ren  in  1  load instruction
- i_lsu_wen  in  1  store instruction
- i_lsu_func3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_lsu_addr  in  XLEN  effective address
- i_lsu_wdata  in  XLEN  store data (rs2)
- i_lsu_alu_res  in  XLEN  result for non-memory instructions
- o_mem_arvalid/i_mem_arready  out/in  1  read address handshake
- o_mem_araddr  out  XLEN  word-aligned read address
- i_mem_rvalid/o_mem_rready  in/out  1  read data handshake
- i_mem_rdata  in  XLEN  read data
- i_mem_rresp  in  2  read response, 00 = OKAY
- o_mem_awvalid/i_mem_awready  out/in  1  write address handshake
- o_mem_awaddr  out  XLEN  word-aligned write address
- o_mem_wvalid/i_mem_wready  out/in  1  write data handshake
- o_mem_wdata  out  XLEN  lane-shifted store data
- o_mem_wstrb  out  4  byte strobes
- i_mem_bvalid/o_mem_bready  in/out  1  write response handshake
- i_mem_bresp  in  2  write response
- o_post_valid  out  1  result valid to WBU
- i_post_ready  in  1  WBU ready
- o_lsu_rd  out  XLEN  result to WBU
- o_lsu_err  out  1  access fault / misalign, qualified by o_post_valid

Behaviour:
- **Reset (async):**
  - state=IDLE; all valid/ready/strobe/data outputs are 0.
  - o_pre_ready=1 (it is combinational on state=IDLE).
  - Reset mid-transaction abandons the access; no bus completion is awaited.
- **Accept:** on i_pre_valid & o_pre_ready, latch all i_lsu_* inputs. If ren and wen are both set, the instruction is treated as a load.
- **FSM:** IDLE, AR, R, WR, B, DONE.
- **IDLE →**
  - AR on a load.
  - WR on a store.
  - DONE on neither, with rd = alu_res.
  - DONE on misalignment, with err=1, rd=0 and no bus traffic.
  - Misaligned means: H/HU with addr[0]=1; W with addr[1:0]≠0.
- **AR:**
  - arvalid=1, araddr = addr & ~3.
  - Stay until arready; then go to R.
  - arvalid and araddr are held stable while waiting.
- **R:**
  - rready=1.
  - On rvalid: rd = extracted load data, err = (rresp≠0), then go to DONE.
- **WR:**
  - awvalid and wvalid assert together. Each drops independently once its own ready is seen.
  - Go to B when both have handshaken; they may complete in the same or different cycles.
- **B:**
  - bready=1.
  - On bvalid: err = (bresp≠0), rd=0, then go to DONE.
- **DONE:**
  - o_post_valid=1; rd and err are held stable.
  - On i_post_ready, go to IDLE. o_post_valid is therefore low for at least one cycle between results, which the downstream edge detector requires.
- **Load extraction:**
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **Store:**
  - wdata = rs2 << (8·addr[1:0]).
  - wstrb: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- **Latency with a zero-wait slave** (accept edge = cycle 0):
  - non-memory: o_post_valid in cycle 1.
  - load: cycle 3.
  - store: cycle 3.

Decomposition:
- defines.v holds:
  - `CPU_Bus
  - func3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW)
  - FSM state encodings
  - RESP_OKAY
- One combinational sub-module, lsu_align: load extract/extend plus store shift/strobe generation.

Test Plan:
- Non-memory, alu_res=0x1234 → o_post_valid in cycle 1, o_lsu_rd=0x1234, no bus activity, handshake then o_post_valid drops.
- LB at 0x8000_0003, slave returns 0x80FF_FFFF → araddr=0x8000_0000, o_lsu_rd=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH at 0x8000_0002, rs2=0xAAAA_BEEF → awaddr=0x8000_0000, wdata=0xBEEF_0000, wstrb=1100. awready delayed 3 cycles relative to wready → exactly one handshake each.
- LW at 0x8000_0001 → DONE in cycle 1, o_lsu_err=1, o_lsu_rd=0, no arvalid.
- Load with rresp=10 → o_lsu_err=1. WBU holds i_post_ready=0 for 4 cycles → o_post_valid and o_lsu_rd stable, o_pre_ready=0 throughout.
- Assert rst while in R with rvalid pending → all outputs 0 immediately, state IDLE, o_pre_ready=1. The next instruction completes normally.
